// File: rtl/preg_file_pkg.sv
`default_nettype none
//============================================================================
// Module      : preg_file_pkg
// Description : Shared constants and FSM encoding for the pointer register
//               file and its clear sequencer.
// Revision    : 1.0 - initial release
//============================================================================
package preg_file_pkg;

    // Default geometry of the pointer register file.
    localparam int c_nreg_dflt   = 64;
    localparam int c_lbid_w_dflt = 12;
    localparam int c_ofs_w_dflt  = 16;

    // Clear sequencer states: either idle or sweeping entries to zero.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } preg_state_e;

    // True when n is a power of two inside the supported register range.
    function automatic bit preg_nreg_ok(input int n);
        return (n >= 4) && (n <= 256) && ((n & (n - 1)) == 0);
    endfunction

endpackage : preg_file_pkg
`default_nettype wire

// File: rtl/preg_file_if.sv
`default_nettype none
//============================================================================
// Module      : preg_file_if
// Description : Command / read-port bundle of the pointer register file.
//               The master side issues commands and read indices, the
//               slave side (the register file) returns data and status.
// Revision    : 1.0 - initial release
//============================================================================
interface preg_file_if #(
    parameter int NREG   = 64,
    parameter int LBID_W = 12,
    parameter int OFS_W  = 16,
    parameter int AW     = $clog2(NREG)
);

    // Clear control and status
    logic              clr;
    logic              busy;

    // Read ports
    logic [AW-1:0]     p0;
    logic [AW-1:0]     p1;
    logic [LBID_W-1:0] lbid0;
    logic [LBID_W-1:0] lbid1;
    logic [OFS_W-1:0]  ofs0;
    logic [OFS_W-1:0]  ofs1;
    logic              vld0;
    logic              vld1;

    // Full-pointer write command
    logic              we;
    logic [AW-1:0]     pw;
    logic [LBID_W-1:0] lbidw;
    logic [OFS_W-1:0]  ofsw;

    // Offset-add command
    logic              ae;
    logic [AW-1:0]     pa;
    logic [OFS_W-1:0]  delta;
    logic              err;

    modport master (
        output clr, p0, p1, we, pw, lbidw, ofsw, ae, pa, delta,
        input  busy, lbid0, lbid1, ofs0, ofs1, vld0, vld1, err
    );

    modport slave (
        input  clr, p0, p1, we, pw, lbidw, ofsw, ae, pa, delta,
        output busy, lbid0, lbid1, ofs0, ofs1, vld0, vld1, err
    );

endinterface : preg_file_if
`default_nettype wire

// File: rtl/preg_clear_seq.sv
`default_nettype none
//============================================================================
// Module      : preg_clear_seq
// Description : Clear sequencer. Walks an index from 0 to NREG-1, one entry
//               per cycle, after reset or a clear request. A clear request
//               arriving mid-sweep restarts the walk at index 0.
// Revision    : 1.0 - initial release
//============================================================================
module preg_clear_seq
    import preg_file_pkg::*;
#(
    parameter int NREG = c_nreg_dflt,
    parameter int AW   = $clog2(NREG)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          i_clr,
    output logic               o_busy,
    output logic [AW-1:0]      o_idx
);

    localparam logic [AW-1:0] c_last_idx = AW'(NREG - 1);

    preg_state_e   r_state;
    preg_state_e   w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;

    // State and index register; reset always starts a fresh sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic: enter/restart on clr, leave after the last entry.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (i_clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (i_clr) begin
                    w_idx_nxt   = '0;
                end else if (r_idx == c_last_idx) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt   = r_idx + AW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign o_busy = (r_state == ST_CLEAR);
    assign o_idx  = r_idx;

endmodule : preg_clear_seq
`default_nettype wire

// File: rtl/preg_file.sv
`default_nettype none
//============================================================================
// Module      : preg_file
// Description : Pointer register file. Each entry holds a label ID, an
//               offset and a valid bit. Two combinational read ports, one
//               full-pointer write command and one offset-add command per
//               cycle. A sequenced clear zeroes one entry per cycle while
//               busy, during which commands are dropped.
// Revision    : 1.0 - initial release
//============================================================================
module preg_file
    import preg_file_pkg::*;
#(
    parameter int NREG   = c_nreg_dflt,
    parameter int LBID_W = c_lbid_w_dflt,
    parameter int OFS_W  = c_ofs_w_dflt,
    parameter int AW     = $clog2(NREG)
) (
    input  wire logic  clk,
    input  wire logic  reset,
    preg_file_if.slave bus
);

    // Entry storage: label IDs, offsets and valid flags kept apart.
    logic [LBID_W-1:0] r_lbid [NREG];
    logic [OFS_W-1:0]  r_ofs  [NREG];
    logic [NREG-1:0]   r_vld;
    logic              r_err;

    logic              w_busy;
    logic [AW-1:0]     w_clr_idx;
    logic              w_cmd_en;
    logic              w_add_req;
    logic              w_add_ok;
    logic              w_add_err;

    // Clear sequencer owns the FSM, the sweep index and busy.
    preg_clear_seq #(
        .NREG (NREG),
        .AW   (AW)
    ) u_clear_seq (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (bus.clr),
        .o_busy (w_busy),
        .o_idx  (w_clr_idx)
    );

    // Commands are honoured only when idle and not being reset this cycle.
    assign w_cmd_en  = !w_busy && !reset;
    // A write to the same index wins over an add and suppresses its error.
    assign w_add_req = bus.ae && !(bus.we && (bus.pw == bus.pa));
    assign w_add_ok  = w_cmd_en && w_add_req && r_vld[bus.pa];
    assign w_add_err = w_cmd_en && w_add_req && !r_vld[bus.pa];

    // Storage update: sweep clear while busy, otherwise write and add.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            if (!reset) begin
                r_lbid[w_clr_idx] <= '0;
                r_ofs[w_clr_idx]  <= '0;
                r_vld[w_clr_idx]  <= 1'b0;
            end
        end else if (w_cmd_en) begin
            if (bus.we) begin
                r_lbid[bus.pw] <= bus.lbidw;
                r_ofs[bus.pw]  <= bus.ofsw;
                r_vld[bus.pw]  <= 1'b1;
            end
            if (w_add_ok) begin
                r_ofs[bus.pa] <= r_ofs[bus.pa] + bus.delta;
            end
        end
    end

    // Error flag: one-cycle pulse after an add aimed at an invalid entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_add_err;
        end
    end

    // Read ports are purely combinational from stored state.
    assign bus.lbid0 = r_lbid[bus.p0];
    assign bus.ofs0  = r_ofs[bus.p0];
    assign bus.vld0  = r_vld[bus.p0];
    assign bus.lbid1 = r_lbid[bus.p1];
    assign bus.ofs1  = r_ofs[bus.p1];
    assign bus.vld1  = r_vld[bus.p1];

    assign bus.busy  = w_busy;
    assign bus.err   = r_err;

endmodule : preg_file
`default_nettype wire

// File: tb/tb_preg_file.sv
`default_nettype none
//============================================================================
// Module      : tb_preg_file
// Description : Self-checking bench for preg_file with directed scenarios
//               and a randomized phase against a behavioural model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_preg_file;

    localparam int NREG   = 64;
    localparam int LBID_W = 12;
    localparam int OFS_W  = 16;
    localparam int AW     = 6;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    preg_file_if #(.NREG(NREG), .LBID_W(LBID_W), .OFS_W(OFS_W), .AW(AW)) bus ();

    preg_file #(.NREG(NREG), .LBID_W(LBID_W), .OFS_W(OFS_W), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: what each entry should hold, plus clear progress.
    int m_lbid  [NREG];
    int m_ofs   [NREG];
    bit m_vld   [NREG];
    bit m_known [NREG];
    bit m_clearing;
    int m_cleared;
    bit m_err;
    bit m_started;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.clr = 0; bus.we = 0; bus.ae = 0;
        bus.pw = '0; bus.pa = '0; bus.lbidw = '0; bus.ofsw = '0; bus.delta = '0;
    endtask

    // Apply the rules to the inputs present at the current clock edge.
    function automatic void model_edge();
        bit e = 0;
        if (reset) begin
            m_clearing = 1; m_cleared = 0; m_err = 0; m_started = 1;
            return;
        end
        if (m_clearing) begin
            m_lbid[m_cleared] = 0; m_ofs[m_cleared] = 0;
            m_vld[m_cleared] = 0;  m_known[m_cleared] = 1;
            if (bus.clr)                 m_cleared = 0;
            else if (m_cleared == NREG-1) m_clearing = 0;
            else                         m_cleared++;
        end else begin
            if (bus.clr) begin m_clearing = 1; m_cleared = 0; end
            if (bus.ae && !(bus.we && bus.pw == bus.pa)) begin
                if (m_vld[bus.pa]) m_ofs[bus.pa] = (m_ofs[bus.pa] + int'(bus.delta)) % 65536;
                else e = 1;
            end
            if (bus.we) begin
                m_lbid[bus.pw] = int'(bus.lbidw); m_ofs[bus.pw] = int'(bus.ofsw);
                m_vld[bus.pw] = 1; m_known[bus.pw] = 1;
            end
        end
        m_err = e;
    endfunction

    task automatic compare_outputs();
        #1;
        if (m_started) begin
            check("busy", 32'(bus.busy), 32'(m_clearing));
            check("err",  32'(bus.err),  32'(m_err));
        end
        if (m_known[bus.p0]) begin
            check("lbid0", 32'(bus.lbid0), 32'(m_lbid[bus.p0]));
            check("ofs0",  32'(bus.ofs0),  32'(m_ofs[bus.p0]));
            check("vld0",  32'(bus.vld0),  32'(m_vld[bus.p0]));
        end
        if (m_known[bus.p1]) begin
            check("lbid1", 32'(bus.lbid1), 32'(m_lbid[bus.p1]));
            check("ofs1",  32'(bus.ofs1),  32'(m_ofs[bus.p1]));
            check("vld1",  32'(bus.vld1),  32'(m_vld[bus.p1]));
        end
    endtask

    // One cycle: compare outputs, take the edge, update the model.
    task automatic tick();
        compare_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic count_busy(input string tag, input int exp);
        int n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < NREG; i++) begin
            bus.p0 = AW'(i); bus.p1 = AW'(NREG-1-i);
            #1;
            if (bus.vld0 !== 1'b0 || bus.vld1 !== 1'b0 || bus.ofs0 !== '0 || bus.lbid0 !== '0)
                check(tag, {bus.vld0, bus.vld1, 14'd0, bus.ofs0}, 32'd0);
            tick();
        end
        check({tag, "_done"}, 32'(bus.vld0), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_lbid[i] = 0; m_ofs[i] = 0; m_vld[i] = 0; m_known[i] = 0;
        end
        m_clearing = 0; m_cleared = 0; m_err = 0; m_started = 0;
        idle_inputs();
        bus.p0 = '0; bus.p1 = '0;
        reset = 1;

        // Reset: one cycle, busy for exactly NREG cycles, then all clear.
        bus.we = 1; bus.ae = 1; bus.clr = 1;
        tick();
        reset = 0;
        idle_inputs();
        count_busy("rst_busy_len", NREG);
        sweep_zero("post_rst_zero");

        // Write then read: not visible in the same cycle, visible next.
        bus.we = 1; bus.pw = 6'd5; bus.lbidw = 12'h123; bus.ofsw = 16'h0010; bus.p0 = 6'd5;
        #1 check("wr_same_cycle_vld0", 32'(bus.vld0), 32'd0);
        tick();
        idle_inputs();
        #1 check("wr_lbid0", 32'(bus.lbid0), 32'h123);
        check("wr_ofs0", 32'(bus.ofs0), 32'h0010);
        check("wr_vld0", 32'(bus.vld0), 32'd1);
        tick();

        // Offset wrap: 0xFFFE + 3 -> 0x0001, then -1 -> 0x0000.
        bus.we = 1; bus.pw = 6'd5; bus.lbidw = 12'h123; bus.ofsw = 16'hFFFE;
        tick();
        idle_inputs(); bus.ae = 1; bus.pa = 6'd5; bus.delta = 16'h0003;
        tick();
        idle_inputs();
        #1 check("add_wrap_up", 32'(bus.ofs0), 32'h0001);
        bus.ae = 1; bus.pa = 6'd5; bus.delta = 16'hFFFF;
        tick();
        idle_inputs();
        #1 check("add_minus1", 32'(bus.ofs0), 32'h0000);
        check("add_lbid_kept", 32'(bus.lbid0), 32'h123);
        tick();

        // Add to an invalid entry: one-cycle err, entry unchanged.
        bus.ae = 1; bus.pa = 6'd9; bus.delta = 16'h0007; bus.p0 = 6'd9;
        tick();
        idle_inputs();
        #1 check("inv_err_pulse", 32'(bus.err), 32'd1);
        check("inv_vld", 32'(bus.vld0), 32'd0);
        check("inv_ofs", 32'(bus.ofs0), 32'd0);
        tick();
        #1 check("inv_err_gone", 32'(bus.err), 32'd0);

        // Write/add collisions.
        bus.we = 1; bus.pw = 6'd4; bus.lbidw = 12'h044; bus.ofsw = 16'h0020;
        tick();
        bus.we = 1; bus.pw = 6'd3; bus.lbidw = 12'h033; bus.ofsw = 16'h0100;
        bus.ae = 1; bus.pa = 6'd3; bus.delta = 16'h0001;
        tick();
        idle_inputs(); bus.p0 = 6'd3;
        #1 check("same_idx_write_wins", 32'(bus.ofs0), 32'h0100);
        check("same_idx_no_err", 32'(bus.err), 32'd0);
        bus.we = 1; bus.pw = 6'd3; bus.lbidw = 12'h033; bus.ofsw = 16'h0100;
        bus.ae = 1; bus.pa = 6'd4; bus.delta = 16'h0001;
        tick();
        idle_inputs(); bus.p0 = 6'd4; bus.p1 = 6'd3;
        #1 check("diff_idx_add", 32'(bus.ofs0), 32'h0021);
        check("diff_idx_write", 32'(bus.ofs1), 32'h0100);
        tick();

        // clr, then reset at clear index 20; commands while busy dropped.
        bus.clr = 1;
        tick();
        bus.clr = 0;
        for (int i = 0; i < 20; i++) begin
            bus.we = 1; bus.pw = AW'($urandom_range(0, NREG-1)); bus.lbidw = 12'hABC; bus.ofsw = 16'h1234;
            bus.ae = 1; bus.pa = AW'($urandom_range(0, NREG-1)); bus.delta = 16'h0005;
            tick();
        end
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 30; i++) begin
            bus.we = 1; bus.pw = AW'($urandom_range(0, NREG-1)); bus.lbidw = 12'hABC; bus.ofsw = 16'h1234;
            bus.ae = 1; bus.pa = 6'd5; bus.delta = 16'h0005;
            #1 check("busy_cmd_no_err", 32'(bus.err), 32'd0);
            tick();
        end
        idle_inputs();
        count_busy("clr_rst_busy_len", NREG - 30);
        sweep_zero("post_clr_rst_zero");

        // Randomized phase against the model.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 499) == 0);
            bus.clr   = ($urandom_range(0, 199) == 0);
            bus.we    = 1'($urandom);
            bus.ae    = 1'($urandom);
            bus.pw    = AW'($urandom_range(0, 11));
            bus.pa    = AW'($urandom_range(0, 11));
            bus.lbidw = LBID_W'($urandom);
            bus.ofsw  = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + OFS_W'($urandom_range(0, 15)) : OFS_W'($urandom);
            bus.delta = OFS_W'($urandom);
            bus.p0    = AW'($urandom_range(0, 15));
            bus.p1    = AW'($urandom_range(0, NREG-1));
            tick();
        end
        reset = 0;
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_preg_file
`default_nettype wire
